// File: rtl/card_pkg.sv
// rtl/card_pkg.sv - shared card code type, constants and dealer FSM states
package card_pkg;

  typedef logic [3:0] card_t;

  localparam card_t CARD_BLANK = 4'd0;
  localparam card_t CARD_ACE   = 4'd1;
  localparam card_t CARD_KING  = 4'd13;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } dealer_state_t;

endpackage

// File: rtl/card_counter.sv
// rtl/card_counter.sv - free-running card code counter, CARD_MIN..CARD_MAX with wrap
module card_counter
  import card_pkg::*;
#(
  parameter int CARD_MIN = 1,
  parameter int CARD_MAX = 13
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] card
);

  // Advance every cycle; never pauses, wraps from CARD_MAX back to CARD_MIN
  always_ff @(posedge clk) begin
    if (rst) begin
      card <= card_t'(CARD_MIN);
    end else if (card == card_t'(CARD_MAX)) begin
      card <= card_t'(CARD_MIN);
    end else begin
      card <= card + 4'd1;
    end
  end

endmodule

// File: rtl/card_dealer.sv
// rtl/card_dealer.sv - deals the running card code into player/dealer hand slots
module card_dealer
  import card_pkg::*;
#(
  parameter int CARD_MIN = 1,
  parameter int CARD_MAX = 13,
  parameter int SLOTS    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       new_hand,
  input  logic       deal_p,
  input  logic       deal_d,
  output logic [3:0] pcard1,
  output logic [3:0] pcard2,
  output logic [3:0] pcard3,
  output logic [3:0] dcard1,
  output logic [3:0] dcard2,
  output logic [3:0] dcard3,
  output logic [1:0] pcount,
  output logic [1:0] dcount,
  output logic       deal_ack,
  output logic       deal_err,
  output logic [3:0] cur_card
);

  dealer_state_t state, next_state;
  card_t         pslot [3];
  card_t         dslot [3];

  logic serve_p, serve_d;
  logic p_full, d_full;
  logic write_p, write_d, refuse;
  logic req;

  card_counter #(
    .CARD_MIN (CARD_MIN),
    .CARD_MAX (CARD_MAX)
  ) u_counter (
    .clk  (clk),
    .rst  (rst),
    .card (cur_card)
  );

  assign req = deal_p || deal_d;

  // State register: reset forces IDLE regardless of held requests
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state: any request in IDLE is consumed (HOLD); HOLD waits for full release.
  // During new_hand a request still moves IDLE to HOLD, otherwise the state is kept.
  always_comb begin
    next_state = state;
    if (new_hand) begin
      if (state == IDLE && req) begin
        next_state = HOLD;
      end
    end else begin
      case (state)
        IDLE:    next_state = req ? HOLD : IDLE;
        HOLD:    next_state = req ? HOLD : IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  // Outputs of the FSM: which hand is served this edge, and whether it is a write or a refusal
  always_comb begin
    serve_p = 1'b0;
    serve_d = 1'b0;
    if (state == IDLE && !new_hand) begin
      serve_p = deal_p;
      serve_d = !deal_p && deal_d;
    end
    p_full  = (pcount == 2'(SLOTS));
    d_full  = (dcount == 2'(SLOTS));
    write_p = serve_p && !p_full;
    write_d = serve_d && !d_full;
    refuse  = (serve_p && p_full) || (serve_d && d_full);
  end

  // Slot registers, counts and one-cycle status pulses; slots fill in order and never shift
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        pslot[i] <= CARD_BLANK;
        dslot[i] <= CARD_BLANK;
      end
      pcount   <= 2'd0;
      dcount   <= 2'd0;
      deal_ack <= 1'b0;
      deal_err <= 1'b0;
    end else begin
      deal_ack <= write_p || write_d;
      deal_err <= refuse;
      if (new_hand) begin
        for (int i = 0; i < 3; i++) begin
          pslot[i] <= CARD_BLANK;
          dslot[i] <= CARD_BLANK;
        end
        pcount <= 2'd0;
        dcount <= 2'd0;
      end else begin
        for (int i = 0; i < 3; i++) begin
          if (write_p && pcount == 2'(i)) pslot[i] <= cur_card;
          if (write_d && dcount == 2'(i)) dslot[i] <= cur_card;
        end
        if (write_p) pcount <= pcount + 2'd1;
        if (write_d) dcount <= dcount + 2'd1;
      end
    end
  end

  assign pcard1 = pslot[0];
  assign pcard2 = pslot[1];
  assign pcard3 = pslot[2];
  assign dcard1 = dslot[0];
  assign dcard2 = dslot[1];
  assign dcard3 = dslot[2];

endmodule

// File: doc/card_dealer.md
Name: card_dealer

Overview:
- Producer side of the 4-bit card code consumed by the team's card-to-seven-segment decoder.
- Free-running card counter; deal requests latch the current card code into the next empty slot of the player or dealer hand.
- Six registered 4-bit slot outputs (3 player, 3 dealer), each feeding one 7-seg decoder instance.
- Slot encoding: 0 = blank, 1 = Ace, 2..10 = pip, 11 = Jack, 12 = Queen, 13 = King.

Parameters:
- CARD_MIN, 1, first card code produced by the counter.
- CARD_MAX, 13, last card code; the counter wraps from here to CARD_MIN.
- SLOTS, 3, slots per hand (pcount and dcount are 2 bits; SLOTS ≤ 3).

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- new_hand  in  1  synchronous clear of both hands.
- deal_p  in  1  level request: deal a card to the player (e.g. debounced pushbutton).
- deal_d  in  1  level request: deal a card to the dealer.
- pcard1, pcard2, pcard3  out  4 each  player slots, registered.
- dcard1, dcard2, dcard3  out  4 each  dealer slots, registered.
- pcount  out  2  number of player cards dealt (0..3).
- dcount  out  2  number of dealer cards dealt (0..3).
- deal_ack  out  1  one-cycle pulse: a card was written.
- deal_err  out  1  one-cycle pulse: request refused because the target hand is full.
- cur_card  out  4  current counter value (debug).

Behaviour:
- Reset (rst=1 at an edge): all slots = 0, pcount = dcount = 0, deal_ack = deal_err = 0, cur_card = CARD_MIN, FSM = IDLE. rst overrides every other input.
- Counter: advances every cycle, CARD_MIN → … → CARD_MAX → CARD_MIN. It never pauses, including during new_hand. It never produces 0, 14 or 15.
- FSM states: IDLE, HOLD.
- IDLE with no request (deal_p = deal_d = 0): stay in IDLE.
- IDLE with deal_p=1 at an edge, player not full:
  - write slot[pcount+1] = cur_card as sampled at that edge; pcount increments.
  - deal_ack = 1 for the following cycle.
  - go to HOLD.
- IDLE with deal_p=0, deal_d=1: same as the player case, applied to the dealer hand.
- Simultaneous deal_p and deal_d in IDLE: the player request is served; the dealer request is dropped with no error.
- Request to a full hand (count == SLOTS): no write, count unchanged, deal_err = 1 for one cycle, go to HOLD.
- HOLD: stay while deal_p or deal_d is high. Return to IDLE on the first edge where both are 0.
- One card per press; latency from request edge to slot/ack visible is one edge.
- new_hand=1 at an edge:
  - slots and counts clear.
  - new_hand beats a simultaneous request: no write, no ack/err.
  - The FSM still moves IDLE → HOLD if a request is high; otherwise the state is unchanged.
- deal_ack and deal_err are never high in the same cycle.
- Slots never shift or reorder. Unwritten slots stay 0, so their displays are blank.

Decomposition:
- Shared package card_pkg holds:
  - typedef card_t (logic [3:0]).
  - constants CARD_BLANK=0, CARD_ACE=1, CARD_KING=13.
  - enum dealer_state_t {IDLE, HOLD}.
- One sub-module, card_counter: wrapping CARD_MIN..CARD_MAX counter with synchronous reset. The top level holds the FSM and slot registers.

Test Plan:
- Reset then free-run 30 cycles → cur_card sequence 1,2,…,13,1,2,…; never 0 or >13. All slots 0, counts 0.
- Raise deal_p at the edge where cur_card=5, hold 4 cycles, release → pcard1=5, pcount=1, exactly one deal_ack pulse. Further edges while held produce no writes.
- Three player presses at cur_card 13, 1, 12, then a fourth press → pcard1..3 = 13, 1, 12; pcount=3. Fourth press gives one deal_err pulse and leaves the slots unchanged.
- deal_p and deal_d rising on the same edge with cur_card=7 → pcard1=7, dcard1=0, dcount=0, one deal_ack. After release, deal_d at cur_card=9 → dcard1=9.
- With pcount=2 and dcount=1, assert new_hand together with deal_d → all slots 0, counts 0, no ack. FSM is in HOLD until deal_d drops; the next press writes slot 1.
- Assert rst mid-HOLD with deal_p still high → outputs reset and FSM = IDLE. With deal_p still held, the first edge after rst is released deals a card (pcard1 = cur_card at that edge).
